// File: rtl/debug_ring_station_multi.sv
// rtl/debug_ring_station_multi.sv - multi-channel DII debug ring station with ingress FIFO, ejection and starvation-bounded injection
module debug_ring_station_multi #(
    parameter int CHANNELS     = 2,
    parameter int BUFFER_SIZE  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                id,
    input  logic [CHANNELS-1:0][17:0]  ring_in,
    output logic [CHANNELS-1:0]        ring_in_ready,
    output logic [CHANNELS-1:0][17:0]  ring_out,
    input  logic [CHANNELS-1:0]        ring_out_ready,
    input  logic [CHANNELS-1:0][17:0]  local_in,
    output logic [CHANNELS-1:0]        local_in_ready,
    output logic [CHANNELS-1:0][17:0]  local_out,
    input  logic [CHANNELS-1:0]        local_out_ready
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {HEAD_IDLE, HEAD_FWD, HEAD_EJECT} head_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_RING, OWN_LOCAL} owner_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [16:0]   mem [BUFFER_SIZE];
        logic [AW:0]   wr_ptr, rd_ptr;
        logic          empty, full, wr_en, rd_en;
        logic [16:0]   head;
        logic          head_match, ring_req, local_prio;
        logic          eject_valid, eject_xfer, out_xfer, out_last;
        logic [17:0]   ring_out_c;
        logic [CW-1:0] wait_cnt;
        head_state_t   head_state, head_next;
        owner_t        owner, owner_eff, owner_next;

        assign empty      = (wr_ptr == rd_ptr);
        assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign head       = mem[rd_ptr[AW-1:0]];
        assign head_match = (head[15:0] == id);
        assign local_prio = (wait_cnt == CW'(STARVE_LIMIT));

        assign ring_in_ready[c] = !full && !rst;
        assign wr_en            = ring_in[c][17] && ring_in_ready[c];

        // Ejection is visible straight from IDLE so a matching head costs no extra cycle.
        assign eject_valid = !rst && !empty &&
                             ((head_state == HEAD_EJECT) || (head_state == HEAD_IDLE && head_match));
        assign eject_xfer  = eject_valid && local_out_ready[c];
        assign ring_req    = !empty && (head_state == HEAD_IDLE) && !head_match;

        always_comb begin
            owner_eff  = owner;
            ring_out_c = '0;
            owner_next = owner;
            head_next  = head_state;
            out_last   = 1'b0;
            if (owner == OWN_NONE) begin
                if (local_prio && local_in[c][17])
                    owner_eff = OWN_LOCAL;
                else if (ring_req)
                    owner_eff = OWN_RING;
                else if (local_in[c][17])
                    owner_eff = OWN_LOCAL;
            end
            if (owner_eff == OWN_RING) begin
                ring_out_c = {!rst && !empty, head};
                out_last   = head[16];
            end else if (owner_eff == OWN_LOCAL) begin
                ring_out_c = {!rst && local_in[c][17], local_in[c][16:0]};
                out_last   = local_in[c][16];
            end
            owner_next = owner_eff;
            if (owner_eff != OWN_NONE && ring_out_c[17] && ring_out_ready[c] && out_last)
                owner_next = OWN_NONE;
            case (head_state)
                HEAD_IDLE: begin
                    if (!empty && head_match)
                        head_next = (eject_xfer && head[16]) ? HEAD_IDLE : HEAD_EJECT;
                    else if (owner_eff == OWN_RING)
                        head_next = (ring_out_c[17] && ring_out_ready[c] && head[16]) ? HEAD_IDLE : HEAD_FWD;
                end
                HEAD_FWD: begin
                    if (ring_out_c[17] && ring_out_ready[c] && head[16])
                        head_next = HEAD_IDLE;
                end
                HEAD_EJECT: begin
                    if (eject_xfer && head[16])
                        head_next = HEAD_IDLE;
                end
                default: head_next = HEAD_IDLE;
            endcase
        end

        assign out_xfer          = ring_out_c[17] && ring_out_ready[c];
        assign rd_en             = (owner_eff == OWN_RING && out_xfer) || eject_xfer;
        assign ring_out[c]       = ring_out_c;
        assign local_out[c]      = {eject_valid, head};
        assign local_in_ready[c] = !rst && (owner_eff == OWN_LOCAL) && ring_out_ready[c];

        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_ptr[AW-1:0]] <= ring_in[c][16:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                head_state <= HEAD_IDLE;
                owner      <= OWN_NONE;
                wait_cnt   <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_en)
                    rd_ptr <= rd_ptr + 1'b1;
                head_state <= head_next;
                owner      <= owner_next;
                // A fresh LOCAL grant resets the starvation count; otherwise count saturating.
                if (owner == OWN_NONE && owner_eff == OWN_LOCAL)
                    wait_cnt <= '0;
                else if (local_in[c][17] && owner != OWN_LOCAL && wait_cnt != CW'(STARVE_LIMIT))
                    wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_debug_ring_station_multi.sv
// tb/tb_debug_ring_station_multi.sv - directed self-checking bench for debug_ring_station_multi
module tb_debug_ring_station_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [15:0]      id;
    logic [1:0][17:0] ring_in, ring_out, local_in, local_out;
    logic [1:0]       ring_in_ready, ring_out_ready, local_in_ready, local_out_ready;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int first_acc;
    int timeouts = 0;
    logic [16:0] rq0[$], rq1[$], lq0[$], lq1[$];
    int rc0[$], rc1[$], lc0[$];

    debug_ring_station_multi #(.CHANNELS(2), .BUFFER_SIZE(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .id(id),
        .ring_in(ring_in), .ring_in_ready(ring_in_ready),
        .ring_out(ring_out), .ring_out_ready(ring_out_ready),
        .local_in(local_in), .local_in_ready(local_in_ready),
        .local_out(local_out), .local_out_ready(local_out_ready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ring_out[0][17] && ring_out_ready[0]) begin rq0.push_back(ring_out[0][16:0]); rc0.push_back(cyc); end
        if (ring_out[1][17] && ring_out_ready[1]) begin rq1.push_back(ring_out[1][16:0]); rc1.push_back(cyc); end
        if (local_out[0][17] && local_out_ready[0]) begin lq0.push_back(local_out[0][16:0]); lc0.push_back(cyc); end
        if (local_out[1][17] && local_out_ready[1]) lq1.push_back(local_out[1][16:0]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_q();
        rq0.delete(); rq1.delete(); lq0.delete(); lq1.delete();
        rc0.delete(); rc1.delete(); lc0.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_ring(input int ch, input logic [16:0] f [16], input int n);
        int i = 0;
        int guard = 0;
        first_acc = -1;
        while (i < n && guard < 200) begin
            ring_in[ch] = {1'b1, f[i]};
            @(negedge clk);
            if (ring_in_ready[ch]) begin
                if (i == 0) first_acc = cyc;
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        ring_in[ch] = '0;
        if (i < n) timeouts++;
    endtask

    task automatic send_local(input int ch, input logic [16:0] f [16], input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            local_in[ch] = {1'b1, f[i]};
            @(negedge clk);
            if (local_in_ready[ch]) i++;
            @(posedge clk); #1;
            guard++;
        end
        local_in[ch] = '0;
        if (i < n) timeouts++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ring_in  = {18'h3_0005, 18'h3_0009};
        local_in = {18'h3_0001, 18'h3_0002};
        tick(1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if ({ring_out[1][17], ring_out[0][17]} !== 2'b00) $display("FAIL reset_ring_out_valid got %b want 00", {ring_out[1][17], ring_out[0][17]}); else passed++;
            checks++; if ({local_out[1][17], local_out[0][17]} !== 2'b00) $display("FAIL reset_local_out_valid got %b want 00", {local_out[1][17], local_out[0][17]}); else passed++;
            checks++; if (ring_in_ready !== 2'b00) $display("FAIL reset_ring_in_ready got %b want 00", ring_in_ready); else passed++;
            checks++; if (local_in_ready !== 2'b00) $display("FAIL reset_local_in_ready got %b want 00", local_in_ready); else passed++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        ring_in = '0;
        local_in = '0;
        @(negedge clk);
        checks++; if (ring_in_ready !== 2'b11) $display("FAIL post_reset_ring_in_ready got %b want 11", ring_in_ready); else passed++;
        checks++; if ({ring_out[1][17], ring_out[0][17]} !== 2'b00) $display("FAIL post_reset_ring_out_valid got %b want 00", {ring_out[1][17], ring_out[0][17]}); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        logic [16:0] pk [16];
        logic [16:0] ex [3];
        pk = '{default: '0};
        pk[0] = 17'h0_0009; pk[1] = 17'h0_A0A0; pk[2] = 17'h1_B0B0;
        ex = '{17'h0_0009, 17'h0_A0A0, 17'h1_B0B0};
        clear_q();
        send_ring(1, pk, 3);
        tick(6);
        checks++; if (rq1.size() !== 3) $display("FAIL fwd_count got %0d want 3", rq1.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rq1[i] !== ex[i]) $display("FAIL fwd_flit%0d got %h want %h", i, rq1[i], ex[i]); else passed++;
        end
        checks++; if (rc1.size() == 0 || rc1[0] !== first_acc + 1) $display("FAIL fwd_latency got %0d want %0d", (rc1.size() == 0) ? -1 : rc1[0], first_acc + 1); else passed++;
        checks++; if (lq1.size() + rq0.size() + lq0.size() !== 0) $display("FAIL fwd_isolation got %0d stray flits want 0", lq1.size() + rq0.size() + lq0.size()); else passed++;
    endtask

    task automatic test_eject_concurrent();
        logic [16:0] pe [16];
        logic [16:0] pl [16];
        pe = '{default: '0};
        pl = '{default: '0};
        pe[0] = 17'h0_0005; pe[1] = 17'h1_C0C0;
        pl[0] = 17'h0_0007; pl[1] = 17'h0_0101; pl[2] = 17'h0_0202; pl[3] = 17'h1_0303;
        clear_q();
        fork
            send_ring(0, pe, 2);
            send_local(0, pl, 4);
        join
        tick(6);
        checks++; if (lq0.size() !== 2) $display("FAIL eject_count got %0d want 2", lq0.size()); else passed++;
        for (int i = 0; i < 2; i++) begin
            checks++; if (lq0[i] !== pe[i]) $display("FAIL eject_flit%0d got %h want %h", i, lq0[i], pe[i]); else passed++;
        end
        checks++; if (rq0.size() !== 4) $display("FAIL inject_count got %0d want 4", rq0.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rq0[i] !== pl[i]) $display("FAIL inject_flit%0d got %h want %h", i, rq0[i], pl[i]); else passed++;
        end
        checks++; if (rc0.size() < 4 || rc0[3] - rc0[0] !== 3) $display("FAIL inject_throughput got span %0d want 3", (rc0.size() < 4) ? -1 : rc0[3] - rc0[0]); else passed++;
        checks++; if (lc0.size() == 0 || rc0.size() < 4 || lc0[0] > rc0[3]) $display("FAIL eject_concurrency got eject start %0d want <= %0d", (lc0.size() == 0) ? -1 : lc0[0], (rc0.size() < 4) ? -1 : rc0[3]); else passed++;
        checks++; if (rq1.size() + lq1.size() !== 0) $display("FAIL eject_isolation got %0d stray flits want 0", rq1.size() + lq1.size()); else passed++;
    endtask

    task automatic test_starvation();
        logic [16:0] pre [16];
        logic [16:0] rest [16];
        logic [16:0] pl [16];
        logic [16:0] ex [18];
        int n;
        pre = '{default: '0};
        rest = '{default: '0};
        pl = '{default: '0};
        for (int k = 0; k < 2; k++) begin
            pre[2*k] = 17'h0_0009; pre[2*k+1] = 17'h1_1000 + 17'(k);
        end
        for (int k = 0; k < 6; k++) begin
            rest[2*k] = 17'h0_0009; rest[2*k+1] = 17'h1_1002 + 17'(k);
        end
        pl[0] = 17'h0_0003; pl[1] = 17'h1_2222;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin ex[n] = pl[0]; ex[n+1] = pl[1]; n += 2; end
            ex[n] = 17'h0_0009; ex[n+1] = 17'h1_1000 + 17'(k); n += 2;
        end
        ring_out_ready[0] = 1'b0;
        send_ring(0, pre, 4);
        clear_q();
        ring_out_ready[0] = 1'b1;
        fork
            send_ring(0, rest, 12);
            send_local(0, pl, 2);
        join
        tick(8);
        checks++; if (rq0.size() !== 18) $display("FAIL starve_count got %0d want 18", rq0.size()); else passed++;
        for (int i = 0; i < 18; i++) begin
            checks++; if (rq0[i] !== ex[i]) $display("FAIL starve_flit%0d got %h want %h", i, rq0[i], ex[i]); else passed++;
        end
        checks++; if (rc0.size() < 18 || rc0[17] - rc0[0] !== 17) $display("FAIL starve_throughput got span %0d want 17", (rc0.size() < 18) ? -1 : rc0[17] - rc0[0]); else passed++;
    endtask

    task automatic test_backpressure();
        logic [16:0] f [6];
        int acc;
        f = '{17'h0_0009, 17'h0_3001, 17'h0_3002, 17'h1_3003, 17'h0_0009, 17'h1_3005};
        clear_q();
        ring_out_ready[1] = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            ring_in[1] = {1'b1, f[acc]};
            @(negedge clk);
            if (ring_in_ready[1]) acc++;
            @(posedge clk); #1;
        end
        ring_in[1] = '0;
        @(negedge clk);
        checks++; if (acc !== 4) $display("FAIL bp_accepted got %0d want 4", acc); else passed++;
        checks++; if (ring_in_ready[1] !== 1'b0) $display("FAIL bp_ready_low got %b want 0", ring_in_ready[1]); else passed++;
        checks++; if (ring_out[1][17] !== 1'b1) $display("FAIL bp_head_waiting got %b want 1", ring_out[1][17]); else passed++;
        @(posedge clk); #1;
        ring_out_ready[1] = 1'b1;
        tick(8);
        checks++; if (rq1.size() !== 4) $display("FAIL bp_drain_count got %0d want 4", rq1.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rq1[i] !== f[i]) $display("FAIL bp_flit%0d got %h want %h", i, rq1[i], f[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [16:0] pm [16];
        logic [16:0] pe [16];
        logic [16:0] pf [16];
        pm = '{default: '0};
        pe = '{default: '0};
        pf = '{default: '0};
        pm[0] = 17'h0_0009; pm[1] = 17'h0_4001; pm[2] = 17'h0_4002; pm[3] = 17'h0_4003; pm[4] = 17'h1_4004;
        pe[0] = 17'h0_0005; pe[1] = 17'h1_5001;
        pf[0] = 17'h0_0009; pf[1] = 17'h1_6001;
        clear_q();
        send_ring(1, pm, 2);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ring_out[1][17] !== 1'b0) $display("FAIL rmid_out_in_reset got %b want 0", ring_out[1][17]); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ring_out[1][17] !== 1'b0) $display("FAIL rmid_fifo_flushed got %b want 0", ring_out[1][17]); else passed++;
        checks++; if (rq1.size() !== 1) $display("FAIL rmid_partial_count got %0d want 1", rq1.size()); else passed++;
        @(posedge clk); #1;
        send_ring(1, pe, 2);
        tick(4);
        checks++; if (lq1.size() !== 2 || lq1[0] !== pe[0] || lq1[1] !== pe[1]) $display("FAIL rmid_eject got %0d flits want 2 (%h %h)", lq1.size(), pe[0], pe[1]); else passed++;
        send_ring(1, pf, 2);
        tick(4);
        checks++; if (rq1.size() !== 3 || rq1[1] !== pf[0] || rq1[2] !== pf[1]) $display("FAIL rmid_forward got %0d flits want 3", rq1.size()); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        id = 16'h0005;
        ring_in = '0;
        local_in = '0;
        ring_out_ready = 2'b11;
        local_out_ready = 2'b11;
        test_reset();
        test_forward();
        test_eject_concurrent();
        test_starvation();
        test_backpressure();
        test_reset_mid_packet();
        checks++; if (timeouts !== 0) $display("FAIL handshake_timeouts got %0d want 0", timeouts); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
